frame_serializer: RTL and testbench
===================================

FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 The module SHALL have parameter WORD_WIDTH, default 32, width of one output word in bits.
REQ-002 The module SHALL have parameter NUM_WORDS, default 8, number of words per frame (range 2..256).
REQ-003 The module SHALL have parameter IDX_WIDTH, default 3, width of the word-index tag; IDX_WIDTH SHALL be at least clog2(NUM_WORDS).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 start_serialize  input  1  request to capture a frame; honoured only when start_ready=1.
REQ-007 start_ready  output  1  high when the block is idle and accepts start_serialize.
REQ-008 msb_first  input  1  word order, sampled with the frame: 1 = top word first, 0 = bottom word first.
REQ-009 input_data  input  WORD_WIDTH*NUM_WORDS  frame to serialize; word k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-010 abort  input  1  cancels the frame in progress.
REQ-011 output_data  output  IDX_WIDTH+WORD_WIDTH  {sequence index, data word}; index in the MSBs.
REQ-012 output_valid  output  1  output_data holds a word.
REQ-013 output_ready  input  1  downstream accepts output_data; a transfer occurs on a rising edge where output_valid=1 and output_ready=1.
REQ-014 serialization_done  output  1  one-cycle pulse after the last word transfers.

Function
REQ-015 The block SHALL implement the states IDLE, SEND and DONE, and all outputs SHALL be registered.
REQ-016 IDLE: start_ready=1, output_valid=0; on an edge with start_serialize=1 -> capture input_data and msb_first into shadow registers, set seq=0, go to SEND.
- output_valid SHALL be 1 in the first cycle after the capture edge (latency 1).
REQ-017 SEND: output_data SHALL be {seq, word}.
- word = shadow word seq when msb_first=0.
- word = shadow word NUM_WORDS-1-seq when msb_first=1.
REQ-018 SEND, transfer with seq<NUM_WORDS-1 -> seq increments and the next word is presented in the following cycle, with no bubble.
REQ-019 SEND, output_valid=1 and output_ready=0 -> output_data and output_valid SHALL hold stable.
- output_ready=0 SHALL NOT stall IDLE or DONE.
REQ-020 SEND, transfer with seq=NUM_WORDS-1 -> go to DONE.
REQ-021 DONE: output_valid=0 and serialization_done=1 for exactly one cycle, then go to IDLE.
- With output_ready held at 1, a frame occupies NUM_WORDS+1 cycles from capture to the return to IDLE.
REQ-022 start_serialize while in SEND or DONE SHALL be ignored; it is not queued.
REQ-023 Changes to input_data or msb_first after the capture edge SHALL NOT affect the frame in progress.
REQ-024 abort=1 in SEND SHALL return the block to IDLE on that edge.
- output_valid=0 and no done pulse.
- abort takes priority over a simultaneous transfer.
REQ-025 abort=1 in IDLE SHALL be ignored.
- abort=1 coinciding with start_serialize in IDLE: the start is honoured.
- abort=1 in DONE: the done pulse still completes.
REQ-026 Unused high bits of the index field (IDX_WIDTH > clog2(NUM_WORDS)) SHALL be zero.

Reset
REQ-027 reset_n=0 SHALL immediately force state IDLE, seq=0, output_data=0, output_valid=0, serialization_done=0 and start_ready=1, regardless of clock.
REQ-028 Reset asserted mid-frame SHALL discard the frame; after release the block SHALL accept a new start on the first edge.

Verification
REQ-029 Default parameters, input_data=256'h0123456789ABCDEF repeated, msb_first=0, output_ready=1, start for one cycle -> output_data sequence 35'h089ABCDEF, 35'h101234567, 35'h289ABCDEF, ... 35'h701234567 on 8 consecutive cycles, then serialization_done=1 for one cycle.
REQ-030 Same frame with msb_first=1 and input_data=256'hFEDCBA9876543210 repeated -> first word 35'h0FEDCBA98, second 35'h176543210, last 35'h776543210.
REQ-031 output_ready low for 3 cycles while seq=2 -> output_data stays at the index-2 word for 3 cycles; no word is lost or duplicated; done is delayed by exactly 3 cycles.
REQ-032 abort at seq=4 coinciding with output_ready=1 -> output_valid=0 on the next cycle, no done pulse, start_ready=1; a new start then begins at index 0.
REQ-033 start_serialize pulsed during SEND with different input_data -> ignored; the current frame completes unchanged.
REQ-034 reset_n asserted asynchronously mid-frame, between clock edges -> all outputs go to their reset values before the next edge.

Source files
------------

// File: rtl/frame_serializer.sv
// frame_serializer: captures a multi-word frame on request and streams it out
// one word per transfer as {sequence index, word}, with valid/ready handshake,
// selectable word order, abort, and a one-cycle completion pulse.
module frame_serializer #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_WORDS  = 8,
  parameter int IDX_WIDTH  = 3
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start_serialize,
  output logic                              start_ready,
  input  logic                              msb_first,
  input  logic [WORD_WIDTH*NUM_WORDS-1:0]   input_data,
  input  logic                              abort,
  output logic [IDX_WIDTH+WORD_WIDTH-1:0]   output_data,
  output logic                              output_valid,
  input  logic                              output_ready,
  output logic                              serialization_done
);

  localparam int FRAME_WIDTH = WORD_WIDTH * NUM_WORDS;
  localparam int OUT_WIDTH   = IDX_WIDTH + WORD_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 r_state, w_state_next;
  logic [IDX_WIDTH-1:0]   r_seq, w_seq_next;
  logic [FRAME_WIDTH-1:0] r_shadow, w_shadow_next;
  logic                   r_msb, w_msb_next;
  logic [OUT_WIDTH-1:0]   r_out_data, w_out_data_next;
  logic                   r_out_valid, w_out_valid_next;
  logic                   r_done, w_done_next;
  logic                   r_start_ready, w_start_ready_next;

  // Word views of the live input frame and of the captured shadow copy
  logic [WORD_WIDTH-1:0]  w_in_words [NUM_WORDS];
  logic [WORD_WIDTH-1:0]  w_sh_words [NUM_WORDS];
  logic [IDX_WIDTH-1:0]   w_seq_inc;
  logic                   w_transfer;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_words
      assign w_in_words[gi] = input_data[gi*WORD_WIDTH +: WORD_WIDTH];
      assign w_sh_words[gi] = r_shadow[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  // Physical word position for a sequence index under the chosen word order
  function automatic logic [IDX_WIDTH-1:0] word_pos(input logic msb,
                                                    input logic [IDX_WIDTH-1:0] seq);
    return msb ? (LAST_IDX - seq) : seq;
  endfunction

  assign w_seq_inc  = r_seq + IDX_WIDTH'(1);
  assign w_transfer = r_out_valid & output_ready;

  // State and registered-output update; reset clears everything immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_seq         <= '0;
      r_shadow      <= '0;
      r_msb         <= 1'b0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_done        <= 1'b0;
      r_start_ready <= 1'b1;
    end else begin
      r_state       <= w_state_next;
      r_seq         <= w_seq_next;
      r_shadow      <= w_shadow_next;
      r_msb         <= w_msb_next;
      r_out_data    <= w_out_data_next;
      r_out_valid   <= w_out_valid_next;
      r_done        <= w_done_next;
      r_start_ready <= w_start_ready_next;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port comes straight from a register
  always_comb begin
    w_state_next       = r_state;
    w_seq_next         = r_seq;
    w_shadow_next      = r_shadow;
    w_msb_next         = r_msb;
    w_out_data_next    = r_out_data;
    w_out_valid_next   = r_out_valid;
    w_done_next        = 1'b0;
    w_start_ready_next = r_start_ready;

    unique case (r_state)
      IDLE: begin
        // abort is meaningless here, so a coincident start is still taken
        if (start_serialize) begin
          w_state_next       = SEND;
          w_seq_next         = '0;
          w_shadow_next      = input_data;
          w_msb_next         = msb_first;
          // First word comes from the live input so it is valid one cycle later
          w_out_data_next    = {{IDX_WIDTH{1'b0}},
                                w_in_words[msb_first ? LAST_IDX : {IDX_WIDTH{1'b0}}]};
          w_out_valid_next   = 1'b1;
          w_start_ready_next = 1'b0;
        end
      end

      SEND: begin
        if (abort) begin
          // abort wins over a simultaneous transfer and suppresses the done pulse
          w_state_next       = IDLE;
          w_seq_next         = '0;
          w_out_data_next    = '0;
          w_out_valid_next   = 1'b0;
          w_start_ready_next = 1'b1;
        end else if (w_transfer) begin
          if (r_seq == LAST_IDX) begin
            w_state_next     = DONE;
            w_out_valid_next = 1'b0;
            w_done_next      = 1'b1;
          end else begin
            // Present the following word on the very next cycle (no bubble)
            w_seq_next      = w_seq_inc;
            w_out_data_next = {w_seq_inc, w_sh_words[word_pos(r_msb, w_seq_inc)]};
          end
        end
        // Without a transfer all outputs simply hold
      end

      DONE: begin
        // Done pulse lasts one cycle regardless of abort or output_ready
        w_state_next       = IDLE;
        w_seq_next         = '0;
        w_start_ready_next = 1'b1;
      end

      default: begin
        w_state_next       = IDLE;
        w_seq_next         = '0;
        w_out_valid_next   = 1'b0;
        w_start_ready_next = 1'b1;
      end
    endcase
  end

  assign start_ready        = r_start_ready;
  assign output_data        = r_out_data;
  assign output_valid       = r_out_valid;
  assign serialization_done = r_done;

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed and randomized frames checked against a
// queue-based reference of the expected word stream.
module tb_frame_serializer;

  localparam int W  = 32;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int FW = W * N;
  localparam int OW = IW + W;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_serialize;
  logic          start_ready;
  logic          msb_first;
  logic [FW-1:0] input_data;
  logic          abort;
  logic [OW-1:0] output_data;
  logic          output_valid;
  logic          output_ready;
  logic          serialization_done;

  int n_checks = 0;
  int n_errors = 0;
  logic [OW-1:0] obs_q[$];

  frame_serializer #(.WORD_WIDTH(W), .NUM_WORDS(N), .IDX_WIDTH(IW)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start_serialize    (start_serialize),
    .start_ready        (start_ready),
    .msb_first          (msb_first),
    .input_data         (input_data),
    .abort              (abort),
    .output_data        (output_data),
    .output_valid       (output_valid),
    .output_ready       (output_ready),
    .serialization_done (serialization_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
    return d;
  endfunction

  // Drive one frame and check every cycle against the expected word list.
  // abort_at: number of words already transferred when abort is raised (-1 = never).
  // stall_mode: 0 = always ready, 1 = random ready, 2 = ready low 3 cycles at seq 2.
  task automatic run_frame(input logic [FW-1:0] data, input logic msb,
                           input int abort_at, input int stall_mode, input string name);
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] cur;
    int   cycles, stalls;
    bit   aborted, fin;
    logic rdy, ab;
    exp_q = {};
    for (int s = 0; s < N; s++)
      exp_q.push_back({IW'(s), data[(msb ? (N - 1 - s) : s) * W +: W]});
    obs_q.delete();

    check({name, ":start_ready_idle"}, 64'(start_ready), 64'(1));
    input_data      = data;
    msb_first       = msb;
    start_serialize = 1'b1;
    abort           = 1'($urandom_range(0, 1));
    output_ready    = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    start_serialize = 1'b0;
    abort           = 1'b0;
    input_data      = rand_frame();
    msb_first       = ~msb;

    cycles = 0; stalls = 0; aborted = 0; fin = 0;
    while (!fin) begin
      check({name, ":valid"}, 64'(output_valid), 64'(1));
      check({name, ":data"}, 64'(output_data), 64'(exp_q[0]));
      check({name, ":no_done"}, 64'(serialization_done), 64'(0));
      check({name, ":busy"}, 64'(start_ready), 64'(0));
      case (stall_mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = !(exp_q.size() == N - 2 && stalls < 3);
      endcase
      ab  = (abort_at == N - exp_q.size());
      cur = output_data;
      output_ready    = rdy;
      abort           = ab;
      start_serialize = 1'($urandom_range(0, 1));
      input_data      = rand_frame();
      if (!rdy) stalls++;
      @(posedge clk); #1;
      cycles++;
      start_serialize = 1'b0;
      abort           = 1'b0;
      if (ab) begin
        aborted = 1; fin = 1;
      end else if (rdy) begin
        obs_q.push_back(cur);
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) fin = 1;
      end
      if (cycles > 500) begin
        check({name, ":timeout"}, 64'(cycles), 64'(0));
        fin = 1;
      end
    end

    if (aborted) begin
      check({name, ":abort_valid"}, 64'(output_valid), 64'(0));
      check({name, ":abort_no_done"}, 64'(serialization_done), 64'(0));
      check({name, ":abort_ready"}, 64'(start_ready), 64'(1));
    end else begin
      check({name, ":send_cycles"}, 64'(cycles), 64'(N + stalls));
      check({name, ":done_valid"}, 64'(output_valid), 64'(0));
      check({name, ":done_pulse"}, 64'(serialization_done), 64'(1));
      check({name, ":done_busy"}, 64'(start_ready), 64'(0));
      abort           = 1'($urandom_range(0, 1));
      start_serialize = 1'b1;
      output_ready    = 1'b0;
      @(posedge clk); #1;
      abort           = 1'b0;
      start_serialize = 1'b0;
      check({name, ":done_end"}, 64'(serialization_done), 64'(0));
      check({name, ":idle_valid"}, 64'(output_valid), 64'(0));
      check({name, ":idle_ready"}, 64'(start_ready), 64'(1));
    end
    $display("frame %s msb=%0d abort_at=%0d stall_mode=%0d cycles=%0d words=%0d",
             name, msb, abort_at, stall_mode, cycles, obs_q.size());
  endtask

  initial begin
    logic [FW-1:0] vec1, vec2, vec;
    vec1 = {4{64'h0123456789ABCDEF}};
    vec2 = {4{64'hFEDCBA9876543210}};
    reset_n = 1'b0; start_serialize = 1'b0; msb_first = 1'b0;
    input_data = '0; abort = 1'b0; output_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset:valid", 64'(output_valid), 64'(0));
    check("reset:data", 64'(output_data), 64'(0));
    check("reset:done", 64'(serialization_done), 64'(0));
    check("reset:ready", 64'(start_ready), 64'(1));
    reset_n = 1'b1;

    run_frame(vec1, 1'b0, -1, 0, "lsb_vec");
    check("lsb_vec:w0", 64'(obs_q[0]), 64'(35'h089ABCDEF));
    check("lsb_vec:w1", 64'(obs_q[1]), 64'(35'h101234567));
    check("lsb_vec:w2", 64'(obs_q[2]), 64'(35'h289ABCDEF));
    check("lsb_vec:w7", 64'(obs_q[7]), 64'(35'h701234567));

    run_frame(vec2, 1'b1, -1, 0, "msb_vec");
    check("msb_vec:w0", 64'(obs_q[0]), 64'(35'h0FEDCBA98));
    check("msb_vec:w1", 64'(obs_q[1]), 64'(35'h176543210));
    check("msb_vec:w7", 64'(obs_q[7]), 64'(35'h776543210));

    run_frame(rand_frame(), 1'b0, -1, 2, "stall3");
    check("stall3:words", 64'(obs_q.size()), 64'(N));

    run_frame(rand_frame(), 1'b0, 4, 0, "abort4");
    check("abort4:words", 64'(obs_q.size()), 64'(4));
    run_frame(rand_frame(), 1'b1, -1, 0, "after_abort");

    // Asynchronous reset between clock edges in the middle of a frame
    vec = rand_frame();
    input_data = vec; msb_first = 1'b0; start_serialize = 1'b1; output_ready = 1'b1;
    @(posedge clk); #1;
    start_serialize = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("async_rst:valid", 64'(output_valid), 64'(0));
    check("async_rst:data", 64'(output_data), 64'(0));
    check("async_rst:done", 64'(serialization_done), 64'(0));
    check("async_rst:ready", 64'(start_ready), 64'(1));
    $display("async reset applied mid-frame");
    #2;
    reset_n = 1'b1;
    run_frame(rand_frame(), 1'b1, -1, 1, "after_reset");

    for (int i = 0; i < 20; i++) begin
      int ab_at;
      ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      run_frame(rand_frame(), 1'($urandom_range(0, 1)), ab_at, 1, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
